// File: rtl/trig_lut_pipe_if.sv
// Request/result handshake bundle between the angle front-end, trig_lut_pipe and the DFPU result bus.
interface trig_lut_pipe_if #(
    parameter int ANGLE_W = 16,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         func_sel;
    logic [ANGLE_W-1:0] angle_in;
    logic [TAG_W-1:0]   tag_in;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        data_out;
    logic [TAG_W-1:0]   tag_out;
    logic               undef_out;

    modport master (
        output in_valid, func_sel, angle_in, tag_in, out_ready,
        input  in_ready, out_valid, data_out, tag_out, undef_out
    );

    modport slave (
        input  in_valid, func_sel, angle_in, tag_in, out_ready,
        output in_ready, out_valid, data_out, tag_out, undef_out
    );
endinterface

// File: rtl/trig_lut_pipe.sv
// Integer-degree sin/cos/tan/csc/sec/cot to IEEE-754 double; result 3 cycles after the accept edge, 1/cycle, stalls ripple back from out_ready.
// Optional TRIG_ERR_CNT_EN adds err_count, a saturating count of delivered undefined results.
module trig_lut_pipe #(
    parameter int ANGLE_W = 16,
    parameter int TAG_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    trig_lut_pipe_if.slave bus
`ifdef TRIG_ERR_CNT_EN
    ,
    output logic [15:0]    err_count
`endif
);
    localparam real         PI   = 3.14159265358979323846;
    localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;

    // Rational points are pinned so that e.g. sin 30 and tan 45 come out exact.
    function automatic logic [63:0] sin_entry(input int i);
        logic [63:0] v;
        case (i)
            0:       v = 64'h0;
            30:      v = 64'h3FE0_0000_0000_0000;
            90:      v = ONE;
            default: v = $realtobits($sin(real'(i) * PI / 180.0));
        endcase
        return v;
    endfunction

    function automatic logic [63:0] tan_entry(input int i);
        logic [63:0] v;
        case (i)
            0:       v = 64'h0;
            45:      v = ONE;
            90:      v = PINF;
            default: v = $realtobits($tan(real'(i) * PI / 180.0));
        endcase
        return v;
    endfunction

    function automatic logic [63:0] sec_entry(input int i);
        logic [63:0] v;
        case (i)
            0:       v = ONE;
            60:      v = 64'h4000_0000_0000_0000;
            90:      v = PINF;
            default: v = $realtobits(1.0 / $cos(real'(i) * PI / 180.0));
        endcase
        return v;
    endfunction

    logic [63:0] sin_rom [91];
    logic [63:0] tan_rom [91];
    logic [63:0] sec_rom [91];

    for (genvar gi = 0; gi < 91; gi++) begin : g_rom
        assign sin_rom[gi] = sin_entry(gi);
        assign tan_rom[gi] = tan_entry(gi);
        assign sec_rom[gi] = sec_entry(gi);
    end

    logic             s1_vld_q, s2_vld_q, s3_vld_q, out_vld_q;
    logic [2:0]       func1_q, func2_q;
    logic [1:0]       q1_q, q2_q, q1_d;
    logic [6:0]       b1_q, b1_d;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag_out_q;
    logic [63:0]      raw2_q, raw2_d, dat3_q, dat3_d, dat_out_q;
    logic             undef3_q, undef3_d, undef_out_q;
    logic [8:0]       a_mod;
    logic [6:0]       idx_mir;
    logic             neg3;
    logic             out_adv, s3_load, s2_load, s1_load;

    // Each rank loads when empty or when its content moves on this cycle.
    assign out_adv      = !out_vld_q || bus.out_ready;
    assign s3_load      = !s3_vld_q  || out_adv;
    assign s2_load      = !s2_vld_q  || s3_load;
    assign s1_load      = !s1_vld_q  || s2_load;
    assign bus.in_ready = s1_load;

    always_comb begin
        a_mod = 9'(bus.angle_in % ANGLE_W'(360));
        q1_d  = 2'(a_mod / 9'd90);
        b1_d  = 7'(a_mod - 9'(q1_d) * 9'd90);
    end

    always_comb begin
        idx_mir = 7'd90 - b1_q;
        raw2_d  = QNAN;
        case (func1_q)
            3'd0:    raw2_d = sin_rom[q1_q[0] ? idx_mir : b1_q];
            3'd1:    raw2_d = sin_rom[q1_q[0] ? b1_q : idx_mir];
            3'd2:    raw2_d = tan_rom[q1_q[0] ? idx_mir : b1_q];
            3'd3:    raw2_d = sec_rom[q1_q[0] ? b1_q : idx_mir];
            3'd4:    raw2_d = sec_rom[q1_q[0] ? idx_mir : b1_q];
            3'd5:    raw2_d = tan_rom[q1_q[0] ? b1_q : idx_mir];
            default: raw2_d = QNAN;
        endcase
    end

    always_comb begin
        case (func2_q)
            3'd0, 3'd3: neg3 = q2_q[1];
            3'd1, 3'd4: neg3 = q2_q[1] ^ q2_q[0];
            3'd2, 3'd5: neg3 = q2_q[0];
            default:    neg3 = 1'b0;
        endcase
        dat3_d   = {raw2_q[63] ^ neg3, raw2_q[62:0]};
        undef3_d = 1'b0;
        // The only infinite table entries are poles, so any inf magnitude is undefined.
        if (func2_q > 3'd5) begin
            dat3_d   = QNAN;
            undef3_d = 1'b1;
        end else if (raw2_q[62:0] == PINF[62:0]) begin
            dat3_d   = PINF;
            undef3_d = 1'b1;
        end else if (raw2_q[62:0] == 63'd0) begin
            dat3_d   = 64'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            func1_q     <= '0;
            func2_q     <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
            b1_q        <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            tag3_q      <= '0;
            tag_out_q   <= '0;
            raw2_q      <= '0;
            dat3_q      <= '0;
            dat_out_q   <= '0;
            undef3_q    <= 1'b0;
            undef_out_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_vld_q <= bus.in_valid;
                if (bus.in_valid) begin
                    func1_q <= bus.func_sel;
                    q1_q    <= q1_d;
                    b1_q    <= b1_d;
                    tag1_q  <= bus.tag_in;
                end
            end
            if (s2_load) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    func2_q <= func1_q;
                    q2_q    <= q1_q;
                    raw2_q  <= raw2_d;
                    tag2_q  <= tag1_q;
                end
            end
            if (s3_load) begin
                s3_vld_q <= s2_vld_q;
                if (s2_vld_q) begin
                    dat3_q   <= dat3_d;
                    undef3_q <= undef3_d;
                    tag3_q   <= tag2_q;
                end
            end
            if (out_adv) begin
                out_vld_q <= s3_vld_q;
                if (s3_vld_q) begin
                    dat_out_q   <= dat3_q;
                    undef_out_q <= undef3_q;
                    tag_out_q   <= tag3_q;
                end
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.data_out  = dat_out_q;
    assign bus.tag_out   = tag_out_q;
    assign bus.undef_out = undef_out_q;

`ifdef TRIG_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 16'd0;
        end else if (out_vld_q && bus.out_ready && undef_out_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif
endmodule
